// File: rtl/misa_o_pkg.sv
// Shared opcodes, width/state encodings and small decode helpers for the MISA-O core.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package misa_o_pkg;

    // Primary opcodes
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_XMEM = 4'h3;
    localparam logic [3:0] OP_XOP  = 4'hF;

    // Extended opcodes (nibble following XOP)
    localparam logic [3:0] XOP_CFG = 4'h1;
    localparam logic [3:0] XOP_SA  = 4'h2;
    localparam logic [3:0] XOP_RSA = 4'h3;

    // XMEM mode nibble bit positions
    localparam int XM_ST  = 3;
    localparam int XM_AM  = 2;
    localparam int XM_DIR = 1;
    localparam int XM_AR  = 0;

    typedef enum logic [1:0] {
        W_UL   = 2'd0,
        W_LK8  = 2'd1,
        W_LK16 = 2'd2
    } width_e;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_OPERAND = 2'd1,
        S_MEM     = 2'd2
    } state_e;

    // What the operand nibbles currently being fetched belong to
    typedef enum logic [2:0] {
        K_LDI   = 3'd0,
        K_XMODE = 3'd1,
        K_XOP   = 3'd2,
        K_CFGL  = 3'd3,
        K_CFGH  = 3'd4
    } kind_e;

    // CFG[1:0] = 2'b11 behaves as the 16-bit width
    function automatic width_e cfg_width(input logic [1:0] sel);
        width_e w;
        case (sel)
            2'b00:   w = W_UL;
            2'b01:   w = W_LK8;
            default: w = W_LK16;
        endcase
        return w;
    endfunction

    // Index of the last LDI operand nibble for a width
    function automatic logic [1:0] last_nibble(input width_e w);
        logic [1:0] n;
        case (w)
            W_UL:    n = 2'd0;
            W_LK8:   n = 2'd1;
            default: n = 2'd3;
        endcase
        return n;
    endfunction

    function automatic logic [15:0] width_mask(input width_e w);
        logic [15:0] m;
        case (w)
            W_UL:    m = 16'h000F;
            W_LK8:   m = 16'h00FF;
            default: m = 16'hFFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/misa_o_xmem_agu.sv
// XMEM address generator: per-byte data address, last-byte flag and updated address register.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the register update is applied by the core on the final byte only.
module misa_o_xmem_agu
    import misa_o_pkg::*;
(
    input  logic [15:0] ra0_i,
    input  logic [15:0] ra1_i,
    input  logic [3:0]  mode_i,
    input  width_e      width_i,
    input  logic        byte_idx_i,
    output logic [14:0] addr_o,
    output logic        last_o,
    output logic [15:0] ra_nxt_o
);

    logic [15:0] base;
    logic [15:0] step;
    logic [15:0] pre;
    logic [15:0] post;
    logic [14:0] eff;

    // Address registers stay untouched until the last byte, so every byte
    // address is derived from the original register value.
    always_comb begin
        base     = mode_i[XM_AR] ? ra1_i : ra0_i;
        step     = (width_i == W_LK16) ? 16'd2 : 16'd1;
        pre      = base - step;
        post     = base + step;
        eff      = (mode_i[XM_AM] && mode_i[XM_DIR]) ? pre[14:0] : base[14:0];
        addr_o   = eff + {14'd0, byte_idx_i};
        last_o   = (width_i == W_LK16) ? byte_idx_i : 1'b1;
        ra_nxt_o = base;
        if (mode_i[XM_AM]) begin
            ra_nxt_o = mode_i[XM_DIR] ? pre : post;
        end
    end

endmodule

// File: rtl/misa_o.sv
// MISA-O nibble-serial accumulator core: fetches and executes one opcode nibble per clock.
// Latency: 1 cycle per nibble, plus 1 cycle per byte for each XMEM access.
// Backpressure: none; memory is assumed to answer combinationally every cycle.
module misa_o
    import misa_o_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [7:0]  CFG_RESET = 8'h4C
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_enable_read,
    output logic        mem_enable_write,
    input  logic [7:0]  mem_data_in,
    output logic [14:0] mem_addr,
    output logic        mem_rw,
    output logic [7:0]  mem_data_out,
    output logic [15:0] test_data,
    output logic        test_carry
);

    state_e      state_q, state_d;
    kind_e       kind_q, kind_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] ra0_q, ra0_d;
    logic [15:0] ra1_q, ra1_d;
    logic [7:0]  cfg_q, cfg_d;
    logic        carry_q, carry_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [3:0]  cfg_lo_q, cfg_lo_d;
    logic [3:0]  mode_q, mode_d;
    logic        byte_q, byte_d;

    width_e      width;
    logic [15:0] mask;
    logic [3:0]  nib;
    logic [16:0] add_sum;
    logic        add_carry;
    logic [14:0] agu_addr;
    logic        agu_last;
    logic [15:0] agu_ra_nxt;

    assign width      = cfg_width(cfg_q[1:0]);
    assign mask       = width_mask(width);
    assign nib        = pc_q[0] ? mem_data_in[7:4] : mem_data_in[3:0];
    assign test_data  = acc_q;
    assign test_carry = carry_q;

    misa_o_xmem_agu u_agu (
        .ra0_i      (ra0_q),
        .ra1_i      (ra1_q),
        .mode_i     (mode_q),
        .width_i    (width),
        .byte_idx_i (byte_q),
        .addr_o     (agu_addr),
        .last_o     (agu_last),
        .ra_nxt_o   (agu_ra_nxt)
    );

    // Width-limited ACC + RA0 + carry, with carry-out taken at bit W.
    always_comb begin
        add_sum = {1'b0, acc_q & mask} + {1'b0, ra0_q & mask} + {16'd0, carry_q};
        case (width)
            W_UL:    add_carry = add_sum[4];
            W_LK8:   add_carry = add_sum[8];
            default: add_carry = add_sum[16];
        endcase
    end

    // Next-state, datapath updates and memory interface outputs.
    always_comb begin
        state_d          = state_q;
        kind_d           = kind_q;
        pc_d             = pc_q;
        acc_d            = acc_q;
        ra0_d            = ra0_q;
        ra1_d            = ra1_q;
        cfg_d            = cfg_q;
        carry_d          = carry_q;
        cnt_d            = cnt_q;
        cfg_lo_d         = cfg_lo_q;
        mode_d           = mode_q;
        byte_d           = byte_q;
        mem_enable_read  = 1'b0;
        mem_enable_write = 1'b0;
        mem_rw           = 1'b0;
        mem_addr         = 15'd0;
        mem_data_out     = 8'd0;

        case (state_q)
            S_FETCH: begin
                mem_addr        = pc_q[15:1];
                mem_enable_read = 1'b1;
                pc_d            = pc_q + 16'd1;
                case (nib)
                    OP_LDI: begin
                        state_d = S_OPERAND;
                        kind_d  = K_LDI;
                        cnt_d   = 2'd0;
                    end
                    OP_ADD: begin
                        acc_d   = add_sum[15:0] & mask;
                        carry_d = add_carry;
                    end
                    OP_XMEM: begin
                        state_d = S_OPERAND;
                        kind_d  = K_XMODE;
                    end
                    OP_XOP: begin
                        state_d = S_OPERAND;
                        kind_d  = K_XOP;
                    end
                    OP_NOP:  ;
                    default: ;
                endcase
            end

            S_OPERAND: begin
                mem_addr        = pc_q[15:1];
                mem_enable_read = 1'b1;
                pc_d            = pc_q + 16'd1;
                case (kind_q)
                    K_LDI: begin
                        // First nibble clears the upper bits: loads are zero-extended
                        if (cnt_q == 2'd0) begin
                            acc_d = {12'd0, nib};
                        end else begin
                            acc_d[{cnt_q, 2'b00} +: 4] = nib;
                        end
                        cnt_d = cnt_q + 2'd1;
                        if (cnt_q == last_nibble(width)) begin
                            state_d = S_FETCH;
                        end
                    end
                    K_XMODE: begin
                        mode_d  = nib;
                        byte_d  = 1'b0;
                        state_d = S_MEM;
                    end
                    K_XOP: begin
                        state_d = S_FETCH;
                        case (nib)
                            XOP_CFG: begin
                                state_d = S_OPERAND;
                                kind_d  = K_CFGL;
                            end
                            XOP_SA: begin
                                acc_d = ra0_q;
                                ra0_d = acc_q;
                            end
                            XOP_RSA: begin
                                acc_d = ra1_q;
                                ra1_d = ra0_q;
                                ra0_d = acc_q;
                            end
                            default: ;
                        endcase
                    end
                    K_CFGL: begin
                        // Held aside so the width never changes mid-instruction
                        cfg_lo_d = nib;
                        kind_d   = K_CFGH;
                    end
                    K_CFGH: begin
                        cfg_d   = {nib, cfg_lo_q};
                        state_d = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end

            S_MEM: begin
                mem_addr = agu_addr;
                if (mode_q[XM_ST]) begin
                    mem_rw           = 1'b1;
                    mem_enable_write = 1'b1;
                    if (width == W_UL) begin
                        mem_data_out = {4'h0, acc_q[3:0]};
                    end else begin
                        mem_data_out = byte_q ? acc_q[15:8] : acc_q[7:0];
                    end
                end else begin
                    mem_enable_read = 1'b1;
                    if (byte_q) begin
                        acc_d[15:8] = mem_data_in;
                    end else if (width == W_UL) begin
                        acc_d = {12'd0, mem_data_in[3:0]};
                    end else begin
                        acc_d = {8'd0, mem_data_in};
                    end
                end
                byte_d = 1'b1;
                if (agu_last) begin
                    state_d = S_FETCH;
                    if (mode_q[XM_AM]) begin
                        if (mode_q[XM_AR]) begin
                            ra1_d = agu_ra_nxt;
                        end else begin
                            ra0_d = agu_ra_nxt;
                        end
                    end
                end
            end

            default: state_d = S_FETCH;
        endcase

        // Reset aborts any access in flight, including a pending store.
        if (rst) begin
            mem_enable_read  = 1'b0;
            mem_enable_write = 1'b0;
            mem_rw           = 1'b0;
            mem_addr         = 15'd0;
            mem_data_out     = 8'd0;
        end
    end

    // Architectural and sequencing state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            kind_q   <= K_LDI;
            pc_q     <= RESET_PC;
            acc_q    <= 16'd0;
            ra0_q    <= 16'd0;
            ra1_q    <= 16'd0;
            cfg_q    <= CFG_RESET;
            carry_q  <= 1'b0;
            cnt_q    <= 2'd0;
            cfg_lo_q <= 4'd0;
            mode_q   <= 4'd0;
            byte_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            pc_q     <= pc_d;
            acc_q    <= acc_d;
            ra0_q    <= ra0_d;
            ra1_q    <= ra1_d;
            cfg_q    <= cfg_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            cfg_lo_q <= cfg_lo_d;
            mode_q   <= mode_d;
            byte_q   <= byte_d;
        end
    end

endmodule

// File: tb/tb_misa_o.sv
// Bench for the MISA-O core: directed program, random programs against an instruction-level model, reset abort.
// Latency: each instruction is given exactly the cycle count the model predicts before ACC/carry are compared.
// Backpressure: none; the bench memory answers combinationally.
module tb_misa_o;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_enable_read;
    logic        mem_enable_write;
    logic [7:0]  mem_data_in;
    logic [14:0] mem_addr;
    logic        mem_rw;
    logic [7:0]  mem_data_out;
    logic [15:0] test_data;
    logic        test_carry;

    logic [7:0]  mem     [32768];
    logic [7:0]  ref_mem [32768];

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt   = 0;

    // Instruction-level reference state
    logic [15:0] m_pc, m_acc, m_ra0, m_ra1;
    logic [7:0]  m_cfg;
    logic        m_c;

    // Constant expectations from the directed program, indexed by instruction number
    int          plan_idx [5] = '{2, 12, 23, 28, 29};
    logic [15:0] plan_acc [5] = '{16'h0080, 16'h0003, 16'h1234, 16'h0000, 16'h0002};
    logic        plan_c   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    misa_o dut (
        .clk              (clk),
        .rst              (rst),
        .mem_enable_read  (mem_enable_read),
        .mem_enable_write (mem_enable_write),
        .mem_data_in      (mem_data_in),
        .mem_addr         (mem_addr),
        .mem_rw           (mem_rw),
        .mem_data_out     (mem_data_out),
        .test_data        (test_data),
        .test_carry       (test_carry)
    );

    always #5 clk = ~clk;

    assign mem_data_in = mem[mem_addr];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: sample the write request mid-cycle, commit it at the edge.
    task automatic tick();
        logic        we;
        logic [14:0] a;
        logic [7:0]  d;
        @(negedge clk);
        we = mem_enable_write;
        a  = mem_addr;
        d  = mem_data_out;
        @(posedge clk);
        if (we) begin
            mem[a] = d;
            wr_cnt++;
        end
    endtask

    function automatic logic [3:0] hexv(input byte c);
        if (c >= "0" && c <= "9") return 4'(c - "0");
        return 4'(c - "A" + 10);
    endfunction

    function automatic logic [3:0] rnib(input logic [15:0] p);
        logic [7:0] b;
        b = ref_mem[p[14:0] >> 0 == 0 ? 15'(p >> 1) : 15'(p >> 1)];
        return p[0] ? b[7:4] : b[3:0];
    endfunction

    function automatic int wbits(input logic [7:0] cfg);
        if (cfg[1:0] == 2'b00) return 4;
        if (cfg[1:0] == 2'b01) return 8;
        return 16;
    endfunction

    task automatic fill_mem(input bit random_fill);
        logic [7:0] b;
        for (int i = 0; i < 32768; i++) begin
            b = random_fill ? 8'($urandom) : 8'h00;
            mem[i]     = b;
            ref_mem[i] = b;
        end
    endtask

    task automatic load_prog(input string p);
        logic [3:0] n;
        for (int i = 0; i < p.len(); i++) begin
            n = hexv(p[i]);
            if (i % 2 == 1) begin
                mem[i / 2][7:4]     = n;
                ref_mem[i / 2][7:4] = n;
            end else begin
                mem[i / 2][3:0]     = n;
                ref_mem[i / 2][3:0] = n;
            end
        end
    endtask

    task automatic model_reset();
        m_pc  = 16'h0000;
        m_acc = 16'h0000;
        m_ra0 = 16'h0000;
        m_ra1 = 16'h0000;
        m_cfg = 8'h4C;
        m_c   = 1'b0;
    endtask

    // Execute one whole instruction; cyc returns its length in clocks.
    task automatic model_step(output int cyc);
        logic [3:0]  op, md, e, lo, hi;
        logic [15:0] t, a, ea;
        logic [7:0]  b;
        int          w, nb;
        int unsigned s, msk;
        cyc = 1;
        w   = wbits(m_cfg);
        op  = rnib(m_pc);
        m_pc++;
        case (op)
            4'h1: begin
                t = 16'h0000;
                for (int i = 0; i < w / 4; i++) begin
                    t = t | (16'(rnib(m_pc)) << (4 * i));
                    m_pc++;
                    cyc++;
                end
                m_acc = t;
            end
            4'h2: begin
                msk   = (32'd1 << w) - 32'd1;
                s     = (32'(m_acc) & msk) + (32'(m_ra0) & msk) + 32'(m_c);
                m_c   = 1'((s >> w) & 32'd1);
                m_acc = 16'(s & msk);
            end
            4'h3: begin
                md = rnib(m_pc);
                m_pc++;
                cyc++;
                nb = (w == 16) ? 2 : 1;
                a  = md[0] ? m_ra1 : m_ra0;
                if (md[2] && md[1]) a = a - 16'(nb);
                t = 16'h0000;
                for (int k = 0; k < nb; k++) begin
                    ea = a + 16'(k);
                    if (md[3]) begin
                        if (w == 4)      b = {4'h0, m_acc[3:0]};
                        else if (k == 0) b = m_acc[7:0];
                        else             b = m_acc[15:8];
                        ref_mem[ea[14:0]] = b;
                    end else begin
                        b = ref_mem[ea[14:0]];
                        if (k == 0) t[7:0]  = b;
                        else        t[15:8] = b;
                    end
                    cyc++;
                end
                if (!md[3]) m_acc = (w == 4) ? {12'h000, t[3:0]} : t;
                if (md[2]) begin
                    if (!md[1]) a = a + 16'(nb);
                    if (md[0]) m_ra1 = a;
                    else       m_ra0 = a;
                end
            end
            4'hF: begin
                e = rnib(m_pc);
                m_pc++;
                cyc++;
                if (e == 4'h1) begin
                    lo = rnib(m_pc);
                    m_pc++;
                    hi = rnib(m_pc);
                    m_pc++;
                    cyc += 2;
                    m_cfg = {hi, lo};
                end else if (e == 4'h2) begin
                    t     = m_acc;
                    m_acc = m_ra0;
                    m_ra0 = t;
                end else if (e == 4'h3) begin
                    t     = m_acc;
                    m_acc = m_ra1;
                    m_ra1 = m_ra0;
                    m_ra0 = t;
                end
            end
            default: ;
        endcase
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        #1;
        check_val("rst_rd_en", 32'(mem_enable_read), 32'd0);
        check_val("rst_wr_en", 32'(mem_enable_write), 32'd0);
        check_val("rst_addr", 32'(mem_addr), 32'd0);
        check_val("rst_rw", 32'(mem_rw), 32'd0);
        check_val("rst_dout", 32'(mem_data_out), 32'd0);
        check_val("rst_acc", 32'(test_data), 32'd0);
        check_val("rst_carry", 32'(test_carry), 32'd0);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic run_steps(input int n, input bit use_plan);
        int cyc;
        for (int s = 1; s <= n; s++) begin
            model_step(cyc);
            repeat (cyc) tick();
            #1;
            check_val("step_acc", 32'(test_data), 32'(m_acc));
            check_val("step_carry", 32'(test_carry), 32'(m_c));
            if (use_plan) begin
                for (int j = 0; j < 5; j++) begin
                    if (plan_idx[j] == s) begin
                        check_val("plan_acc", 32'(test_data), 32'(plan_acc[j]));
                        check_val("plan_carry", 32'(test_carry), 32'(plan_c[j]));
                    end
                end
            end
        end
    endtask

    initial begin
        int bad;
        rst = 1'b1;

        // Directed program covering CFG, LDI, SA/RSA, XMEM in all widths and ADD carry
        fill_mem(1'b0);
        load_prog({"F1E410800F210900F2F3F1C4153C133830F1D41B53C1003834",
                   "F1E4143213D1000037F1C411F21F22"});
        do_reset();
        run_steps(29, 1'b1);
        check_val("mem80", 32'(mem[15'h0080]), 32'h05);
        check_val("mem81", 32'(mem[15'h0081]), 32'h5B);
        check_val("mem82", 32'(mem[15'h0082]), 32'h00);
        check_val("mem90", 32'(mem[15'h0090]), 32'h34);
        check_val("mem91", 32'(mem[15'h0091]), 32'h12);

        // Random memory images executed as programs
        for (int r = 0; r < 3; r++) begin
            fill_mem(1'b1);
            do_reset();
            run_steps(300, 1'b0);
            bad = 0;
            for (int i = 0; i < 32768; i++) begin
                if (mem[i] !== ref_mem[i]) bad++;
            end
            check_val("rand_mem_image", 32'(bad), 32'd0);
        end

        // Reset during the second byte of an LK16 store
        fill_mem(1'b0);
        load_prog("F1E410A00F21FEEB38");
        do_reset();
        repeat (16) tick();
        wr_cnt = 0;
        repeat (3) tick();
        #1;
        rst = 1'b1;
        #1;
        check_val("abort_wr_en", 32'(mem_enable_write), 32'd0);
        check_val("abort_addr", 32'(mem_addr), 32'd0);
        tick();
        #1;
        check_val("abort_acc", 32'(test_data), 32'd0);
        check_val("abort_carry", 32'(test_carry), 32'd0);
        check_val("abort_wr_cnt", 32'(wr_cnt), 32'd1);
        check_val("abort_byte0", 32'(mem[15'h00A0]), 32'hEF);
        check_val("abort_byte1", 32'(mem[15'h00A1]), 32'h00);
        rst = 1'b0;
        repeat (9) tick();
        #1;
        check_val("abort_restart_acc", 32'(test_data), 32'h00A0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/misa_o.md
Name: misa_o

Overview:
- MISA-O is a minimal nibble-serial 16-bit accumulator CPU core.
- It fetches 4-bit opcodes packed two per byte and executes them one nibble per clock.
- Operand width is configurable to 4, 8 or 16 bits, and it reaches data memory through XMEM load/store using two address registers.
- It sits at the top of the processor and talks directly to a single unified byte-wide memory with combinational read. ACC and carry are exported as debug ports.

Parameters:
- RESET_PC, 16'h0000: reset value of the nibble program counter.
- CFG_RESET, 8'h4C: configuration register reset value (UL mode).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_enable_read  output  1  high while the core samples mem_data_in (fetch or XMEM load).
- mem_enable_write  output  1  high for one cycle per byte stored; memory writes on that rising edge.
- mem_data_in  input  8  combinational read data for mem_addr.
- mem_addr  output  15  byte address.
- mem_rw  output  1  1 = write cycle, 0 = read cycle.
- mem_data_out  output  8  store data; valid while mem_enable_write = 1.
- test_data  output  16  current ACC.
- test_carry  output  1  current carry flag.

Behaviour:
- State: PC[15:0] (nibble address), ACC[15:0], RA0[15:0], RA1[15:0], CFG[7:0], carry.
- Reset values: PC=RESET_PC, ACC=RA0=RA1=0, CFG=CFG_RESET, carry=0.
- Outputs during reset: enables 0, mem_addr 0, mem_rw 0, mem_data_out 0.
- Fetch:
  - mem_addr = PC[15:1].
  - Nibble = PC[0] ? mem_data_in[7:4] : mem_data_in[3:0], so the low nibble executes first.
  - One nibble is consumed per cycle and PC increments by 1 per nibble.
  - mem_enable_read=1, mem_rw=0.
- Width W from CFG[1:0]: 00 = UL (4 bits, N=1 nibble); 01 = LK8 (8 bits, N=2); 10 = LK16 (16 bits, N=4); 11 = treated as LK16. CFG[7:2] are stored but have no effect.
- Primary opcodes:
  - 0x0 NOP.
  - 0x1 LDI: the next N nibbles, least significant first, are loaded into ACC zero-extended to 16 bits.
  - 0x2 ADD: ACC[W-1:0] = ACC + RA0 + carry; carry = carry-out at bit W; upper ACC bits cleared.
  - 0x3 XMEM: the next nibble is the mode, bit3 ST, bit2 AM, bit1 DIR, bit0 AR.
  - 0xF XOP: the next nibble is an extended opcode.
  - Others: execute as NOP.
- Extended opcodes:
  - 0x1 CFG: the next two nibbles (low, then high) are written to CFG.
  - 0x2 SA: swap ACC and RA0.
  - 0x3 RSA: rotate ACC←RA1, RA1←RA0, RA0←ACC, all simultaneously.
  - Others: NOP.
- XMEM:
  - Address A = AR ? RA1 : RA0. Byte count B = 1 in UL/LK8, 2 in LK16.
  - Byte k is accessed at A+k (A[14:0] used); 16-bit words are little-endian.
  - Each byte takes one extra cycle with mem_addr = data address.
  - Store cycle: mem_rw=1, mem_enable_write=1, mem_enable_read=0. mem_data_out = {4'h0, ACC[3:0]} in UL, otherwise the ACC byte k.
  - Load cycle: mem_enable_read=1, mem_rw=0; the byte is captured at the cycle edge. UL loads ACC = byte[3:0]; LK8 loads ACC = byte; LK16 loads ACC = {byte1, byte0}. All loads zero-extend.
  - AM=1, DIR=0: post-increment, the selected RA += B after the access.
  - AM=1, DIR=1: pre-decrement, the selected RA -= B and the access uses the new value.
  - AM=0: RA unchanged.
  - RA arithmetic wraps modulo 2^16. Carry is never changed by XMEM.
  - The fetch resumes at the next nibble after the final memory cycle.
- Reset asserted mid-instruction or mid-XMEM aborts immediately; no write is issued in the reset cycle.
- PC wraps modulo 2^16.

Decomposition:
- Package misa_o_pkg: primary opcode constants (NOP, LDI, ADD, XMEM, XOP), extended opcode constants (CFG, SA, RSA), width enum (UL, LK8, LK16), XMEM mode bit indices, FSM state enum (FETCH, OPERAND, MEM).
- One sub-module is natural: misa_o_xmem_agu, the address/byte sequencer that computes the address, the per-byte address and the RA update.

Test Plan:
- CFG 0x4E, LDI 0,8,0,0 → ACC=0x0080. SA; LDI 0x0090; SA; RSA → RA0=0x0080, RA1=0x0090.
- UL mode: LDI 5; XMEM mode C → MEM[0x80]=05, RA0=0x81. LDI 3; XMEM mode 8 → MEM[0x81]=03. XMEM mode 0 → ACC=0x0003.
- LK8 mode: LDI 0x5B; XMEM mode C → MEM[0x81]=5B, RA0=0x82. LDI 0; XMEM mode 8; XMEM mode 4 → ACC=0x0000, RA0=0x83.
- LK16 mode: LDI 0x1234; XMEM mode D → MEM[0x90]=34, MEM[0x91]=12, RA1=0x92. LDI 0; XMEM mode 7 (pre-dec RA1) → ACC=0x1234, RA1=0x90.
- UL mode: LDI 0xF; set RA0=0x0001 via SA; ADD → ACC=0x0000, carry=1. Next ADD → ACC=0x0002, carry=0.
- Assert rst during an LK16 store after byte 0 → no second write, ACC=0, PC=RESET_PC.
